// File: rtl/rfphoenix_mem_issue.sv
// rfPhoenix memory issue stage: pops the request queue head, runs one or two 128-bit bus beats, returns one response.
// Optional bus watchdog enabled by defining RFPHOENIX_MEM_ISSUE_TIMEOUT_EN.
package rfphoenix_mem_pkg;
  localparam logic [3:0] MR_LOAD  = 4'd1;
  localparam logic [3:0] MR_LOADZ = 4'd2;
  localparam logic [3:0] MR_STORE = 4'd3;
  localparam logic [2:0] SZ_BYT   = 3'd0;
  localparam logic [2:0] SZ_WYDE  = 3'd1;
  localparam logic [2:0] SZ_TETRA = 3'd2;
  localparam logic [2:0] SZ_OCTA  = 3'd3;

  typedef struct packed {
    logic [7:0]   tag;
    logic [3:0]   func;
    logic [2:0]   size;
    logic [31:0]  adr;
    logic [127:0] dat;
  } sMemoryRequest;
endpackage

module rfphoenix_mem_issue
  import rfphoenix_mem_pkg::*;
#(
  parameter int AWID  = 32,
  parameter int TOVAL = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            q_valid,
  input  sMemoryRequest   q_req,
  output logic            q_rd,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [15:0]     sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [127:0]    dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [127:0]    dat_i,
  output logic            resp_valid,
  output sMemoryRequest   resp,
  output logic            resp_err,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, RESP} state_t;

  state_t        state;
  sMemoryRequest req;
  logic [127:0]  beat0;

  function automatic logic [15:0] size_sel(input logic [2:0] size);
    case (size)
      SZ_BYT:   size_sel = 16'h0001;
      SZ_WYDE:  size_sel = 16'h0003;
      SZ_TETRA: size_sel = 16'h000F;
      default:  size_sel = 16'h00FF;
    endcase
  endfunction

  function automatic logic [31:0] sel32_of(input logic [2:0] size, input logic [3:0] off);
    sel32_of = {16'h0000, size_sel(size)} << off;
  endfunction

  function automatic logic func_ok(input logic [3:0] func);
    func_ok = (func == MR_LOAD) || (func == MR_LOADZ) || (func == MR_STORE);
  endfunction

  // Align the two-line window to the access and sign- or zero-extend from its top byte.
  function automatic logic [127:0] load_ext(input logic [255:0] lines, input logic [3:0] off,
                                            input logic [2:0] size, input logic zext);
    logic [63:0]        sh;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic signed [31:0] s32;
    logic signed [63:0] s64;
    sh  = 64'(lines >> {off, 3'b000});
    s8  = sh[7:0];
    s16 = sh[15:0];
    s32 = sh[31:0];
    s64 = sh;
    case (size)
      SZ_BYT:   load_ext = zext ? {120'h0, sh[7:0]}  : 128'(s8);
      SZ_WYDE:  load_ext = zext ? {112'h0, sh[15:0]} : 128'(s16);
      SZ_TETRA: load_ext = zext ? {96'h0, sh[31:0]}  : 128'(s32);
      default:  load_ext = zext ? {64'h0, sh}        : 128'(s64);
    endcase
  endfunction

  logic [31:0]    q_sel32;
  logic [31:0]    r_sel32;
  logic           split;
  logic [3:0]     off;
  logic [AWID-5:0] line_nxt;
  logic [255:0]   beat_lines;
  logic           timeout;
  logic           beat_err;
  sMemoryRequest  done_resp;

  assign q_sel32    = sel32_of(q_req.size, q_req.adr[3:0]);
  assign r_sel32    = sel32_of(req.size, req.adr[3:0]);
  assign split      = |r_sel32[31:16];
  assign off        = req.adr[3:0];
  assign line_nxt   = req.adr[AWID-1:4] + {{(AWID-5){1'b0}}, 1'b1};
  assign beat_lines = (state == ISSUE1) ? {dat_i, beat0} : {128'h0, dat_i};
  assign beat_err   = err_i | timeout;
  assign busy       = (state != IDLE);

  always_comb begin
    done_resp = req;
    if (req.func != MR_STORE)
      done_resp.dat = load_ext(beat_lines, off, req.size, req.func == MR_LOADZ);
  end

`ifdef RFPHOENIX_MEM_ISSUE_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       stb_set;
  assign stb_set = ((state == IDLE) && q_valid && func_ok(q_req.func)) ||
                   ((state == ISSUE1) && !cyc_o);
  // Fires on the TOVAL-th unterminated strobe cycle, so stb_o is high for TOVAL cycles.
  assign timeout = stb_o && !ack_i && !err_i && (wd_cnt == 8'(TOVAL - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             wd_cnt <= 8'd0;
    else if (stb_set)                     wd_cnt <= 8'd0;
    else if (stb_o && !ack_i && !err_i)   wd_cnt <= wd_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      beat0      <= '0;
      q_rd       <= 1'b0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      sel_o      <= '0;
      adr_o      <= '0;
      dat_o      <= '0;
      resp_valid <= 1'b0;
      resp       <= '0;
      resp_err   <= 1'b0;
    end else begin
      q_rd       <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (q_valid) begin
          req  <= q_req;
          q_rd <= 1'b1;
          if (func_ok(q_req.func)) begin
            state <= ISSUE0;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= (q_req.func == MR_STORE);
            sel_o <= q_sel32[15:0];
            adr_o <= {q_req.adr[AWID-1:4], 4'h0};
            dat_o <= q_req.dat << {q_req.adr[3:0], 3'b000};
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp       <= q_req;
            resp_err   <= 1'b1;
          end
        end
        ISSUE0: if (beat_err || ack_i) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          beat0 <= dat_i;
          if (beat_err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp       <= req;
            resp_err   <= 1'b1;
          end else if (split) begin
            state <= ISSUE1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp       <= done_resp;
            resp_err   <= 1'b0;
          end
        end
        // First ISSUE1 cycle keeps cyc_o low to separate the two beats.
        ISSUE1: if (!cyc_o) begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          sel_o <= r_sel32[31:16];
          adr_o <= {line_nxt, 4'h0};
          dat_o <= req.dat >> {5'd16 - {1'b0, off}, 3'b000};
        end else if (beat_err || ack_i) begin
          cyc_o      <= 1'b0;
          stb_o      <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp       <= beat_err ? req : done_resp;
          resp_err   <= beat_err;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfphoenix_mem_issue.sv
// Randomized self-checking bench for rfphoenix_mem_issue against a byte-level request model.
module tb_rfphoenix_mem_issue;
  import rfphoenix_mem_pkg::*;

  localparam int AWID  = 32;
  localparam int TOVAL = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            q_valid = 1'b0;
  sMemoryRequest   q_req = '0;
  logic            q_rd;
  logic            cyc_o, stb_o, we_o;
  logic [15:0]     sel_o;
  logic [AWID-1:0] adr_o;
  logic [127:0]    dat_o;
  logic            ack_i = 1'b0;
  logic            err_i = 1'b0;
  logic [127:0]    dat_i = '0;
  logic            resp_valid;
  sMemoryRequest   resp;
  logic            resp_err;
  logic            busy;

  always #5 clk = ~clk;

  rfphoenix_mem_issue #(.AWID(AWID), .TOVAL(TOVAL)) dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_req(q_req), .q_rd(q_rd),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .resp_valid(resp_valid), .resp(resp), .resp_err(resp_err), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int rv_cnt = 0;

  always @(posedge clk) begin
    if (q_rd) rd_cnt++;
    if (resp_valid) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] exp_sel32(input int off, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[off + k] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] exp_load(input logic [127:0] l0, input logic [127:0] l1,
                                            input int off, input int n, input bit zext);
    logic [7:0]   mem [32];
    logic [127:0] v;
    for (int k = 0; k < 16; k++) begin
      mem[k]      = l0[k*8 +: 8];
      mem[k + 16] = l1[k*8 +: 8];
    end
    v = '0;
    for (int k = 0; k < n; k++) v[k*8 +: 8] = mem[off + k];
    if (!zext && mem[off + n - 1][7])
      for (int k = n; k < 16; k++) v[k*8 +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic bus_beat(input int w, input bit e, input bit both, input logic [127:0] line);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk("wait_stb", stb_o, 1'b1);
      chk("wait_noresp", resp_valid, 1'b0);
    end
    ack_i = !e || both;
    err_i = e;
    dat_i = line;
    @(negedge clk);
    ack_i = 1'b0;
    err_i = 1'b0;
  endtask

  task automatic run_req(input sMemoryRequest r, input int w0, input int w1, input bit e0,
                         input bit e1, input bit both, input logic [127:0] l0,
                         input logic [127:0] l1, output sMemoryRequest got);
    int off, n, rd0, rv0;
    logic [31:0] s32, base;
    bit split, fok, werr, st;
    off   = int'(r.adr[3:0]);
    n     = nbytes(r.size);
    s32   = exp_sel32(off, n);
    split = |s32[31:16];
    fok   = r.func inside {MR_LOAD, MR_LOADZ, MR_STORE};
    st    = (r.func == MR_STORE);
    werr  = e0 || (split && e1);
    base  = {r.adr[31:4], 4'h0};
    rd0   = rd_cnt;
    rv0   = rv_cnt;
    q_valid = 1'b1;
    q_req   = r;
    @(negedge clk);
    q_valid = 1'b0;
    if (!fok) begin
      chk("bad_resp_valid", resp_valid, 1'b1);
      chk("bad_resp_err", resp_err, 1'b1);
      chk("bad_cyc", cyc_o, 1'b0);
      chk("bad_tag", resp.tag, r.tag);
    end else begin
      chk("q_rd", q_rd, 1'b1);
      chk("b0_cyc", cyc_o, 1'b1);
      chk("b0_we", we_o, st);
      chk("b0_sel", sel_o, s32[15:0]);
      chk("b0_adr", adr_o, base);
      if (st)
        for (int k = off; k < 16; k++)
          if (s32[k]) chk("b0_lane", dat_o[k*8 +: 8], r.dat[(k - off)*8 +: 8]);
      bus_beat(w0, e0, both, l0);
      if (split && !e0) begin
        chk("gap_cyc", cyc_o, 1'b0);
        @(negedge clk);
        chk("b1_cyc", cyc_o, 1'b1);
        chk("b1_sel", sel_o, s32[31:16]);
        chk("b1_adr", adr_o, base + 32'd16);
        if (st)
          for (int k = 0; k < 16; k++)
            if (s32[16 + k]) chk("b1_lane", dat_o[k*8 +: 8], r.dat[(16 + k - off)*8 +: 8]);
        bus_beat(w1, e1, both, l1);
      end
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_err", resp_err, werr);
      chk("resp_tag", resp.tag, r.tag);
      chk("resp_adr", resp.adr, r.adr);
      chk("end_cyc", cyc_o, 1'b0);
      if (!werr)
        chk("resp_dat", resp.dat,
            st ? r.dat : exp_load(l0, l1, off, n, r.func == MR_LOADZ));
    end
    got = resp;
    @(negedge clk);
    chk("resp_pulse", resp_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cyc", cyc_o, 1'b0);
    chk("rd_once", rd_cnt - rd0, 1);
    chk("resp_once", rv_cnt - rv0, 1);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_cyc", cyc_o, 1'b0);
    chk("rst_stb", stb_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp", resp_valid, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic sMemoryRequest mk(input logic [7:0] tag, input logic [3:0] func,
                                       input logic [2:0] size, input logic [31:0] adr,
                                       input logic [127:0] dat);
    sMemoryRequest r;
    r.tag = tag; r.func = func; r.size = size; r.adr = adr; r.dat = dat;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    sMemoryRequest r, got;
    logic [127:0] l0, l1;
    int rv0, stb_low;

    repeat (2) @(negedge clk);
    chk("rst_q_rd", q_rd, 1'b0);
    chk("rst_cyc0", cyc_o, 1'b0);
    chk("rst_stb0", stb_o, 1'b0);
    chk("rst_we", we_o, 1'b0);
    chk("rst_sel", sel_o, 16'h0);
    chk("rst_adr", adr_o, '0);
    chk("rst_dat", dat_o, '0);
    chk("rst_rv", resp_valid, 1'b0);
    chk("rst_respv", resp, '0);
    chk("rst_rerr", resp_err, 1'b0);
    chk("rst_busy0", busy, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);

    l0 = rnd128();
    l0[63:32] = 32'h8011_2233;
    run_req(mk(8'h01, MR_LOAD, SZ_TETRA, 32'h104, '0), 0, 0, 0, 0, 0, l0, rnd128(), got);
    chk("t1_lit", got.dat, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h8011_2233});

    l0 = rnd128();
    l1 = rnd128();
    run_req(mk(8'h02, MR_LOADZ, SZ_OCTA, 32'h10C, '0), 1, 2, 0, 0, 0, l0, l1, got);
    chk("t2_lit", got.dat, {64'h0, l1[31:0], l0[127:96]});

    run_req(mk(8'h03, MR_STORE, SZ_WYDE, 32'h20F, 128'hBEEF), 0, 0, 0, 0, 0, '0, '0, got);
    chk("t3_err", got.tag, 8'h03);

    run_req(mk(8'h04, MR_LOAD, SZ_OCTA, 32'h30A, '0), 1, 0, 1, 0, 1, rnd128(), rnd128(), got);

    // Never-acknowledged beat: watchdog abort or indefinite wait.
    rv0 = rv_cnt;
    q_valid = 1'b1;
    q_req   = mk(8'h05, MR_LOAD, SZ_BYT, 32'h400, '0);
    @(negedge clk);
    q_valid = 1'b0;
    chk("hang_stb0", stb_o, 1'b1);
`ifdef RFPHOENIX_MEM_ISSUE_TIMEOUT_EN
    for (int i = 1; i < TOVAL; i++) begin
      @(negedge clk);
      chk("wd_stb_hi", stb_o, 1'b1);
    end
    @(negedge clk);
    chk("wd_stb_lo", stb_o, 1'b0);
    chk("wd_resp", resp_valid, 1'b1);
    chk("wd_err", resp_err, 1'b1);
    @(negedge clk);
`else
    stb_low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!stb_o) stb_low++;
    end
    chk("hang_stb_low", stb_low, 0);
    chk("hang_noresp", rv_cnt - rv0, 0);
    pulse_reset();
`endif

    rv0 = rv_cnt;
    q_valid = 1'b1;
    q_req   = mk(8'h06, MR_LOADZ, SZ_WYDE, 32'h500, '0);
    @(negedge clk);
    q_valid = 1'b0;
    chk("mid_cyc", cyc_o, 1'b1);
    pulse_reset();
    repeat (3) @(negedge clk);
    chk("mid_noresp", rv_cnt - rv0, 0);
    run_req(mk(8'h07, MR_LOAD, SZ_WYDE, 32'h51F, '0), 0, 1, 0, 0, 0, rnd128(), rnd128(), got);

    for (int i = 0; i < 150; i++) begin
      int pick;
      logic [3:0] f;
      pick = int'($urandom_range(0, 9));
      if (pick < 3)      f = MR_LOAD;
      else if (pick < 6) f = MR_LOADZ;
      else if (pick < 9) f = MR_STORE;
      else               f = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(4, 15));
      r = mk(8'(i + 16), f, 3'($urandom_range(0, 7)), $urandom, rnd128());
      run_req(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1, rnd128(), rnd128(), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
